// File: rtl/pong_pkg.sv
// Shared definitions for the Pong datapath.
//   DY_*        : encodings of the 2-bit paddle command bus (bit0 = up/+y,
//                 bit1 = down/-y; 2'b11 is never produced).
//   ai_state_t  : states of the computer opponent FSM in paddle_ai.
package pong_pkg;

  localparam logic [1:0] DY_NONE = 2'b00;
  localparam logic [1:0] DY_UP   = 2'b01;
  localparam logic [1:0] DY_DOWN = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REACT    = 2'd1,
    TRACK    = 2'd2,
    RECENTER = 2'd3
  } ai_state_t;

endpackage

// File: rtl/paddle_ai_if.sv
// Signal bundle between the Pong datapath and the paddle_ai opponent.
//   pause, side, frame_tick, ball_x, ball_y, ball_dir_x, paddle_y : to the AI
//   dy    : registered up/down command back to the paddle block
//   state : current FSM state, exported for observation
// Handshake: there is no valid/ready pair. frame_tick is a one-cycle strobe
// and is the only qualifier; the AI samples every input on the tick cycle and
// dy is a level that holds between ticks (the consumer may read it anytime).
interface paddle_ai_if #(
  parameter int BIT_WIDTH = 10
);
  import pong_pkg::*;

  logic                 pause;
  logic                 side;
  logic                 frame_tick;
  logic [BIT_WIDTH-1:0] ball_x;
  logic [BIT_WIDTH-1:0] ball_y;
  logic                 ball_dir_x;
  logic [BIT_WIDTH-1:0] paddle_y;
  logic [1:0]           dy;
  ai_state_t            state;

  modport slave (
    input  pause, side, frame_tick, ball_x, ball_y, ball_dir_x, paddle_y,
    output dy, state
  );

  modport master (
    output pause, side, frame_tick, ball_x, ball_y, ball_dir_x, paddle_y,
    input  dy, state
  );

endinterface

// File: rtl/paddle_ai_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5.
// Maximal length: cycles through all 255 nonzero values.
//   clk : clock
//   rst : asynchronous active-low reset (loads the seed)
//   en  : advance one step this cycle
//   q   : current register value
module paddle_ai_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic fb;

  // Taps 8,6,5,4 map to bits 7,5,4,3 with a left shift.
  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 8'hA5;
    end else if (en) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/paddle_ai.sv
// paddle_ai: CPU opponent that drives the paddle dy command bus.
// Tracks the ball (deadbanded, frame-paced) after a reaction delay while the
// ball approaches this paddle's half, and re-centres the paddle otherwise.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : paddle_ai_if.slave (game inputs in, dy and FSM state out)
// Optional feature: define PADDLE_AI_JITTER_EN to add an LFSR-driven target
// offset in [-4,+3] while tracking; without it the target is exactly ball_y.
module paddle_ai
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH    = 10,
  parameter int MAX_Y        = 480,
  parameter int ZONE_X       = 320,
  parameter int DEADBAND     = 4,
  parameter int REACT_FRAMES = 3
) (
  input  logic          clk,
  input  logic          rst,
  paddle_ai_if.slave    bus
);

  // Two guard bits so a jittered target near either end cannot wrap.
  localparam int EW = BIT_WIDTH + 2;
  localparam logic signed [EW-1:0]  DB_POS = EW'(DEADBAND);
  localparam logic signed [EW-1:0]  DB_NEG = -DB_POS;
  localparam logic [BIT_WIDTH-1:0]  CENTER = BIT_WIDTH'(MAX_Y / 2);
  localparam logic [BIT_WIDTH-1:0]  ZONE   = BIT_WIDTH'(ZONE_X);
  localparam logic [7:0]            RF_CNT = 8'(REACT_FRAMES);

  ai_state_t  state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] dy, dy_n;

  logic             approach;
  logic [EW-1:0]    track_target;
  logic [1:0]       track_dy;
  logic [1:0]       home_dy;

  function automatic logic [1:0] steer(input logic [EW-1:0] target,
                                       input logic [BIT_WIDTH-1:0] py);
    logic signed [EW-1:0] err;
    err = $signed(target - {2'b00, py});
    if (err > DB_POS)      return DY_UP;
    else if (err < DB_NEG) return DY_DOWN;
    else                   return DY_NONE;
  endfunction

  assign approach = (!bus.side &&  bus.ball_dir_x && (bus.ball_x >= ZONE)) ||
                    ( bus.side && !bus.ball_dir_x && (bus.ball_x <  ZONE));

`ifdef PADDLE_AI_JITTER_EN
  logic [7:0] lfsr_q;

  paddle_ai_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (bus.frame_tick && !bus.pause),
    .q   (lfsr_q)
  );

  // Offset lfsr[2:0]-4 lies in [-4,+3]; two's complement wrap is intended.
  assign track_target = {2'b00, bus.ball_y} + EW'(lfsr_q[2:0]) - EW'(4);
`else
  assign track_target = {2'b00, bus.ball_y};
`endif

  assign track_dy = steer(track_target, bus.paddle_y);
  assign home_dy  = steer({2'b00, CENTER}, bus.paddle_y);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      dy    <= DY_NONE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dy    <= dy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dy_n    = dy;
    if (bus.pause) begin
      // Pause wins over a coincident tick: output drops, everything else holds.
      dy_n = DY_NONE;
    end else if (bus.frame_tick) begin
      case (state)
        IDLE: begin
          dy_n = DY_NONE;
          if (approach) begin
            state_n = REACT;
            cnt_n   = RF_CNT;
          end
        end
        REACT: begin
          dy_n = DY_NONE;
          if (!approach)          state_n = RECENTER;
          else if (cnt == 8'd1)   state_n = TRACK;
          else                    cnt_n   = cnt - 8'd1;
        end
        TRACK: begin
          if (!approach) begin
            state_n = RECENTER;
            dy_n    = home_dy;
          end else begin
            dy_n    = track_dy;
          end
        end
        RECENTER: begin
          if (approach) begin
            state_n = REACT;
            cnt_n   = RF_CNT;
            dy_n    = DY_NONE;
          end else begin
            dy_n = home_dy;
            if (home_dy == DY_NONE) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.dy    = dy;
  assign bus.state = state;

endmodule

// File: tb/tb_paddle_ai.sv
module tb_paddle_ai;
  import pong_pkg::*;

  localparam int BW       = 10;
  localparam int MAX_Y    = 480;
  localparam int ZONE_X   = 320;
  localparam int DEADBAND = 4;
  localparam int RF       = 3;
  localparam int CENTER   = MAX_Y / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  paddle_ai_if #(.BIT_WIDTH(BW)) bus ();

  paddle_ai #(
    .BIT_WIDTH    (BW),
    .MAX_Y        (MAX_Y),
    .ZONE_X       (ZONE_X),
    .DEADBAND     (DEADBAND),
    .REACT_FRAMES (RF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  // ---------------- reference model ----------------
  // Behaviour described as "how many reaction ticks have elapsed" plus
  // two flags, rather than as a state register with a down counter.
  int         m_react;   // -1: not reacting; else reaction ticks completed
  bit         m_track;
  bit         m_home;
  logic [1:0] m_dy;
  logic [7:0] m_lfsr;
  logic [1:0] exp_q[$];

  function automatic logic [1:0] steer_ref(input int target, input int py);
    int e;
    e = target - py;
    if (e > DEADBAND)  return 2'b01;
    if (e < -DEADBAND) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit approach_ref(input bit sd, input bit dir, input int bx);
    return (!sd && dir && bx >= ZONE_X) || (sd && !dir && bx < ZONE_X);
  endfunction

  function automatic ai_state_t exp_state();
    if (m_track)      return TRACK;
    if (m_react >= 0) return REACT;
    if (m_home)       return RECENTER;
    return IDLE;
  endfunction

  task automatic model_reset();
    m_react = -1;
    m_track = 0;
    m_home  = 0;
    m_dy    = 2'b00;
    m_lfsr  = 8'hA5;
  endtask

  task automatic model_step(input bit tick, input bit pse, input int bx,
                            input int by, input bit dir, input int py, input bit sd);
    bit app;
    if (pse) begin
      m_dy = 2'b00;
      return;
    end
    if (!tick) return;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    app = approach_ref(sd, dir, bx);
    if (m_track) begin
      if (!app) begin
        m_track = 0;
        m_home  = 1;
        m_dy    = steer_ref(CENTER, py);
      end else begin
        m_dy = steer_ref(by, py);
      end
    end else if (m_react >= 0) begin
      m_dy = 2'b00;
      if (!app) begin
        m_react = -1;
        m_home  = 1;
      end else begin
        m_react++;
        if (m_react == RF) begin
          m_react = -1;
          m_track = 1;
        end
      end
    end else if (m_home) begin
      if (app) begin
        m_home  = 0;
        m_react = 0;
        m_dy    = 2'b00;
      end else begin
        m_dy = steer_ref(CENTER, py);
        if (m_dy == 2'b00) m_home = 0;
      end
    end else begin
      m_dy = 2'b00;
      if (app) m_react = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit tick, input bit pse, input int bx, input int by,
                      input bit dir, input int py, input bit sd);
    @(negedge clk);
    bus.frame_tick = tick;
    bus.pause      = pse;
    bus.ball_x     = BW'(bx);
    bus.ball_y     = BW'(by);
    bus.ball_dir_x = dir;
    bus.paddle_y   = BW'(py);
    bus.side       = sd;
    model_step(tick, pse, bx, by, dir, py, sd);
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    bus.pause      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.side       = 1'b0;
    bus.ball_x     = '0;
    bus.ball_y     = '0;
    bus.ball_dir_x = 1'b0;
    bus.paddle_y   = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reset, then four approaching ticks: the FSM ends in TRACK with dy=00.
  task automatic goto_track(input int by, input int py);
    do_reset();
    for (int i = 0; i < RF + 1; i++) step(1, 0, 400, by, 1, py, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.dy !== 2'b00) $display("FAIL reset_dy: got %b want 00", bus.dy);
    else passes++;
    checks++;
    if (bus.state !== IDLE) $display("FAIL reset_state: got %0d want %0d", bus.state, IDLE);
    else passes++;

    goto_track(300, 240);
    step(1, 0, 400, 300, 1, 240, 0);
    checks++;
    if (bus.dy !== 2'b01) $display("FAIL reset_pre_dy: got %b want 01", bus.dy);
    else passes++;
    // Assert reset mid-cycle, away from any clock edge.
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.dy !== 2'b00) $display("FAIL reset_async_dy: got %b want 00", bus.dy);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.state !== IDLE) $display("FAIL reset_release_state: got %0d want %0d", bus.state, IDLE);
    else passes++;
  endtask

  task automatic test_react_delay();
    do_reset();
    for (int t = 1; t <= RF + 2; t++) begin
      ai_state_t  ws;
      logic [1:0] wd;
      step(1, 0, 400, 300, 1, 240, 0);
      ws = (t <= RF) ? REACT : TRACK;
      wd = (t == RF + 2) ? 2'b01 : 2'b00;
      checks++;
      if (bus.state !== ws) $display("FAIL react_state_t%0d: got %0d want %0d", t, bus.state, ws);
      else passes++;
      checks++;
      if (bus.dy !== wd) $display("FAIL react_dy_t%0d: got %b want %b", t, bus.dy, wd);
      else passes++;
    end
  endtask

  task automatic test_deadband();
    int         by_tab[3] = '{244, 245, 235};
    logic [1:0] dy_tab[3] = '{2'b00, 2'b01, 2'b10};
    goto_track(240, 240);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 400, by_tab[i], 1, 240, 0);
      checks++;
      if (bus.dy !== dy_tab[i])
        $display("FAIL deadband_y%0d: got %b want %b", by_tab[i], bus.dy, dy_tab[i]);
      else passes++;
    end
  endtask

  task automatic test_recenter();
    int py_tab[4] = '{140, 180, 220, 232};
    goto_track(300, 100);
    step(1, 0, 400, 300, 0, 100, 0);
    checks++;
    if (bus.state !== RECENTER || bus.dy !== 2'b01)
      $display("FAIL recenter_enter: got state %0d dy %b want %0d 01", bus.state, bus.dy, RECENTER);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 400, 300, 0, py_tab[i], 0);
      checks++;
      if (bus.state !== RECENTER || bus.dy !== 2'b01)
        $display("FAIL recenter_ramp_%0d: got state %0d dy %b want %0d 01",
                 py_tab[i], bus.state, bus.dy, RECENTER);
      else passes++;
    end
    step(1, 0, 400, 300, 0, 236, 0);
    checks++;
    if (bus.state !== IDLE || bus.dy !== 2'b00)
      $display("FAIL recenter_done: got state %0d dy %b want %0d 00", bus.state, bus.dy, IDLE);
    else passes++;
  endtask

  task automatic test_pause();
    goto_track(200, 240);
    step(1, 0, 400, 200, 1, 240, 0);
    checks++;
    if (bus.dy !== 2'b10) $display("FAIL pause_pre_dy: got %b want 10", bus.dy);
    else passes++;
    // Tick coincident with the first pause cycle must be ignored.
    step(1, 1, 400, 200, 1, 240, 0);
    checks++;
    if (bus.dy !== 2'b00 || bus.state !== TRACK)
      $display("FAIL pause_first: got dy %b state %0d want 00 %0d", bus.dy, bus.state, TRACK);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 100, 200, 0, 240, 0);
      checks++;
      if (bus.dy !== 2'b00 || bus.state !== TRACK)
        $display("FAIL pause_hold_%0d: got dy %b state %0d want 00 %0d", i, bus.dy, bus.state, TRACK);
      else passes++;
    end
    step(0, 0, 400, 200, 1, 240, 0);
    checks++;
    if (bus.dy !== 2'b00 || bus.state !== TRACK)
      $display("FAIL pause_release: got dy %b state %0d want 00 %0d", bus.dy, bus.state, TRACK);
    else passes++;
    step(1, 0, 400, 200, 1, 240, 0);
    checks++;
    if (bus.dy !== 2'b10 || bus.state !== TRACK)
      $display("FAIL pause_resume: got dy %b state %0d want 10 %0d", bus.dy, bus.state, TRACK);
    else passes++;
  endtask

  task automatic test_random();
    int bx, by, py;
    bit dir, sd;
    do_reset();
    bx = 400; by = 300; py = 240; dir = 1; sd = 0;
    for (int i = 0; i < 600; i++) begin
      bit tick, pse;
      logic [1:0] want;
      if ($urandom_range(0, 9) == 0) begin
        bx  = $urandom_range(0, 639);
        dir = $urandom_range(0, 1);
        sd  = $urandom_range(0, 1);
      end
      by   = $urandom_range(0, MAX_Y - 1);
      if ($urandom_range(0, 3) == 0) py = $urandom_range(0, MAX_Y - 1);
      tick = ($urandom_range(0, 2) == 0);
      pse  = ($urandom_range(0, 11) == 0);
      step(tick, pse, bx, by, dir, py, sd);
      exp_q.push_back(m_dy);
      want = exp_q.pop_front();
      checks++;
      if (bus.dy !== want) $display("FAIL rand_dy_%0d: got %b want %b", i, bus.dy, want);
      else passes++;
      checks++;
      if (bus.state !== exp_state())
        $display("FAIL rand_state_%0d: got %0d want %0d", i, bus.state, exp_state());
      else passes++;
    end
  endtask

`ifdef PADDLE_AI_JITTER_EN
  task automatic test_jitter();
    int period;
    do_reset();
    checks++;
    if (dut.u_lfsr.q !== 8'hA5) $display("FAIL jitter_seed: got %h want a5", dut.u_lfsr.q);
    else passes++;
    period = 0;
    for (int i = 1; i <= 300; i++) begin
      // ball_y == paddle_y, so any tracking dy means the offset left [-4,+3].
      step(1, 0, 400, 240, 1, 240, 0);
      checks++;
      if (dut.u_lfsr.q !== m_lfsr || dut.u_lfsr.q === 8'h00)
        $display("FAIL jitter_lfsr_%0d: got %h want %h", i, dut.u_lfsr.q, m_lfsr);
      else passes++;
      checks++;
      if (bus.dy !== 2'b00) $display("FAIL jitter_offset_%0d: got %b want 00", i, bus.dy);
      else passes++;
      if (period == 0 && dut.u_lfsr.q === 8'hA5) period = i;
    end
    checks++;
    if (period != 255) $display("FAIL jitter_period: got %0d want 255", period);
    else passes++;
  endtask
`endif

  initial begin
    rst = 1'b0;
    model_reset();
    test_reset();
`ifdef PADDLE_AI_JITTER_EN
    test_jitter();
`else
    test_react_delay();
    test_deadband();
    test_recenter();
    test_pause();
    test_random();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
